lea_keysched_seq: RTL and testbench

Sequential, parametrised LEA key scheduler covering all three LEA key sizes (128/192/256). It accepts a key on a start pulse and emits one 192-bit round key per cycle over a valid/ready stream: 24, 28 or 32 round keys depending on key length. It sits between the key-load interface and the LEA round datapath and replaces a fully unrolled, combinational 128-bit-only schedule with a small iterative core that supports backpressure.

---
 rtl/lea_keysched_seq.sv | 217 +++++++++++++++++++++
 tb/tb_lea_keysched_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lea_keysched_seq.sv
// Iterative LEA key scheduler (128/192/256-bit keys), one 192-bit round key per handshake.
// Define LEA_KEYSCHED_STORE_EN to build the 32x192 round-key store behind rd_idx/rd_data.
module lea_keysched_seq #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [191:0] rk_out,
    output logic [4:0]   rk_idx,
    output logic         rk_last,
    input  logic [4:0]   rd_idx,
    output logic [191:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_OUT
    } state_t;

    localparam logic [31:0] DELTA [8] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
        32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
    };
    localparam logic [4:0] ROT [8] = '{5'd1, 5'd3, 5'd6, 5'd11, 5'd13, 5'd17, 5'd0, 5'd0};

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] d;
        d = {x, x} << s;
        return d[63:32];
    endfunction

    function automatic logic [2:0] mod6(input logic [4:0] x);
        return 3'(x % 5'd6);
    endfunction

    // One word update: T' = ROL_r(T + ROL_{i+j}(delta)), j picks the word rotation.
    function automatic logic [31:0] upd(input logic [31:0] t, input logic [31:0] d,
                                        input logic [4:0] i, input logic [2:0] j);
        return rol32(t + rol32(d, i + 5'(j)), ROT[j]);
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_t [8];
    logic [31:0]   w_t_nxt [8];
    logic [4:0]    r_i;
    logic [1:0]    r_len;
    logic          r_err;
    logic          r_vld;
    logic          r_last;
    logic [191:0]  r_rk;
    logic [4:0]    r_idx;
    logic [191:0]  w_rk;
    logic [31:0]   w_delta;
    logic [4:0]    w_last_idx;
    logic [7:0]    w_prod;
    logic [2:0]    w_base;
    logic          w_key_ok;
    logic          w_accept;
    logic          w_bad;
    logic          w_xfer;
    logic          w_step;

    assign w_key_ok = (key_len != 2'd3) && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
    assign w_accept = (r_state == S_IDLE) && start && w_key_ok;
    assign w_bad    = (r_state == S_IDLE) && start && !w_key_ok;
    assign w_xfer   = r_vld && rk_ready;
    // A non-final transfer computes the next round in the same cycle, so full rate has no bubbles.
    assign w_step   = (r_state == S_GEN) || ((r_state == S_OUT) && w_xfer && !r_last);

    // 6i mod 8 is the first word touched by LEA-256 round i.
    assign w_prod = 8'(r_i) * 8'd6;
    assign w_base = w_prod[2:0];

    always_comb begin
        w_delta    = DELTA[r_i[2:0]];
        w_last_idx = 5'd31;
        case (r_len)
            2'd0: begin
                w_delta    = DELTA[{1'b0, r_i[1:0]}];
                w_last_idx = 5'd23;
            end
            2'd1: begin
                w_delta    = DELTA[mod6(r_i)];
                w_last_idx = 5'd27;
            end
            default: begin
                w_delta    = DELTA[r_i[2:0]];
                w_last_idx = 5'd31;
            end
        endcase
    end

    always_comb begin
        w_t_nxt = r_t;
        w_rk    = '0;
        case (r_len)
            2'd0: begin
                for (int j = 0; j < 4; j++) begin
                    w_t_nxt[j] = upd(r_t[j], w_delta, r_i, 3'(j));
                end
                w_rk = {w_t_nxt[0], w_t_nxt[1], w_t_nxt[2], w_t_nxt[1], w_t_nxt[3], w_t_nxt[1]};
            end
            2'd1: begin
                for (int j = 0; j < 6; j++) begin
                    w_t_nxt[j] = upd(r_t[j], w_delta, r_i, 3'(j));
                end
                w_rk = {w_t_nxt[0], w_t_nxt[1], w_t_nxt[2], w_t_nxt[3], w_t_nxt[4], w_t_nxt[5]};
            end
            default: begin
                // Word k is the (k - base) mod 8 -th update of this round; two words are untouched.
                for (int k = 0; k < 8; k++) begin
                    if ((3'(k) - w_base) < 3'd6) begin
                        w_t_nxt[k] = upd(r_t[k], w_delta, r_i, 3'(k) - w_base);
                    end
                end
                for (int j = 0; j < 6; j++) begin
                    w_rk[191 - 32*j -: 32] = w_t_nxt[w_base + 3'(j)];
                end
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_GEN;
            S_GEN:   w_state_nxt = S_OUT;
            S_OUT:   if (w_xfer && r_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
            r_rk   <= '0;
            r_idx  <= '0;
            r_i    <= '0;
            r_len  <= '0;
            for (int k = 0; k < 8; k++) begin
                r_t[k] <= '0;
            end
        end else begin
            r_err <= w_bad;
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    r_t[k] <= key_in[32*k +: 32];
                end
                r_i   <= '0;
                r_len <= key_len;
            end else if (w_step) begin
                r_t    <= w_t_nxt;
                r_i    <= r_i + 5'd1;
                r_rk   <= w_rk;
                r_idx  <= r_i;
                r_last <= (r_i == w_last_idx);
                r_vld  <= 1'b1;
            end else if (w_xfer) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;
    assign rk_valid = r_vld;
    assign rk_out   = r_rk;
    assign rk_idx   = r_idx;
    assign rk_last  = r_last;

`ifdef LEA_KEYSCHED_STORE_EN
    logic [191:0] r_store [32];
    logic [191:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (w_xfer && !rst) begin
            r_store[r_idx] <= r_rk;
        end
    end

    // Registered read: a same-cycle write to rd_idx is seen one access later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_store[rd_idx];
        end
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_rd_idx;
    assign w_unused_rd_idx = ^rd_idx;
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_lea_keysched_seq.sv
// Scoreboard bench for lea_keysched_seq: stimulus pushes golden round keys, a monitor pops on each transfer.
module tb_lea_keysched_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic         rk_ready = 1'b0;
    logic [4:0]   rd_idx = 5'd0;
    logic         busy;
    logic         err;
    logic         rk_valid;
    logic [191:0] rk_out;
    logic [4:0]   rk_idx;
    logic         rk_last;
    logic [191:0] rd_data;

    lea_keysched_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .err      (err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   idx;
        logic         last;
        logic [191:0] rk;
    } exp_t;

    exp_t         q[$];
    logic [191:0] gold [32];
    int           n_vec = 0;
    int           n_fail = 0;

    localparam logic [31:0] DLT [8] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
        32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
    };
    localparam int RT [6] = '{1, 3, 6, 11, 13, 17};

    localparam logic [255:0] K128 = {128'h0, 32'hf0e1d2c3, 32'hb4a59687, 32'h78695a4b, 32'h3c2d1e0f};
    localparam logic [191:0] K128_RK0 =
        {32'h003a0fd4, 32'h02497010, 32'h194f7db1, 32'h02497010, 32'h090d0883, 32'h02497010};
    localparam logic [255:0] K192 = {64'h0, 192'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_f0e1d2c3_b4a59687};
    localparam logic [255:0] K256 =
        256'h1f2e3d4c_5b6a7988_97a6b5c4_d3e2f100_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] brol(input logic [31:0] x, input int s);
        int a;
        a = s % 32;
        if (a == 0) return x;
        return (x << a) | (x >> (32 - a));
    endfunction

    function automatic int nrounds(input logic [1:0] len);
        return 24 + 4 * int'(len);
    endfunction

    task automatic build_expected(input logic [1:0] len, input logic [255:0] key);
        logic [31:0]  t [8];
        logic [191:0] rk;
        exp_t         e;
        int           n;
        int           w;
        n = nrounds(len);
        for (int j = 0; j < 8; j++) t[j] = key[32*j +: 32];
        for (int i = 0; i < n; i++) begin
            rk = '0;
            if (len == 2'd0) begin
                for (int j = 0; j < 4; j++) t[j] = brol(t[j] + brol(DLT[i % 4], i + j), RT[j]);
                rk = {t[0], t[1], t[2], t[1], t[3], t[1]};
            end else if (len == 2'd1) begin
                for (int j = 0; j < 6; j++) t[j] = brol(t[j] + brol(DLT[i % 6], i + j), RT[j]);
                for (int j = 0; j < 6; j++) rk[191 - 32*j -: 32] = t[j];
            end else begin
                for (int j = 0; j < 6; j++) begin
                    w = (6 * i + j) % 8;
                    t[w] = brol(t[w] + brol(DLT[i % 8], i + j), RT[j]);
                end
                for (int j = 0; j < 6; j++) rk[191 - 32*j -: 32] = t[(6 * i + j) % 8];
            end
            gold[i] = rk;
            e.idx  = 5'(i);
            e.last = (i == n - 1);
            e.rk   = rk;
            q.push_back(e);
        end
    endtask

    // Monitor: pops on every transfer and checks that a stalled key does not move.
    initial begin
        exp_t         e;
        bit           held;
        logic [191:0] h_rk;
        logic [4:0]   h_idx;
        logic         h_last;
        held = 0;
        h_rk = '0;
        h_idx = '0;
        h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("stall_rk_out", rk_out, h_rk);
                    chk("stall_idx_last", 192'({rk_idx, rk_last}), 192'({h_idx, h_last}));
                    held = 0;
                end
                if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_key: got idx %0d with empty queue", rk_idx);
                    end else begin
                        e = q.pop_front();
                        chk("rk_idx", 192'(rk_idx), 192'(e.idx));
                        chk("rk_last", 192'(rk_last), 192'(e.last));
                        chk("rk_out", rk_out, e.rk);
                    end
                end else if (rk_valid === 1'b1) begin
                    held   = 1;
                    h_rk   = rk_out;
                    h_idx  = rk_idx;
                    h_last = rk_last;
                end
            end
        end
    end

    task automatic run(input logic [1:0] len, input logic [255:0] key, input bit rnd,
                       input bit poke, input bit chk_k0);
        int n;
        int cyc;
        n = nrounds(len);
        build_expected(len, key);
        start    = 1'b1;
        key_len  = len;
        key_in   = key;
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 192'(busy), 192'(1));
        cyc = 0;
        while (busy && cyc < 400) begin
            start = 1'b0;
            if (poke && cyc == 5) begin
                start   = 1'b1;
                key_len = 2'd3;
                key_in  = ~key;
            end
            if (poke && cyc == 8) begin
                start   = 1'b1;
                key_len = 2'd0;
                key_in  = ~key;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk("first_valid", 192'(rk_valid), 192'(1));
                chk("first_idx", 192'(rk_idx), 192'(0));
                if (chk_k0) chk("lea128_rk0", rk_out, K128_RK0);
            end
            if (poke && cyc == 6) chk("err_while_busy", 192'(err), 192'(0));
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        chk("sched_done", 192'(busy), 192'(0));
        if (!rnd) chk("cycle_count", 192'(cyc), 192'(n + 1));
        chk("queue_drained", 192'(q.size()), 192'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 192'(busy), 192'(0));
        chk({tag, "_err"}, 192'(err), 192'(0));
        chk({tag, "_valid"}, 192'(rk_valid), 192'(0));
        chk({tag, "_last"}, 192'(rk_last), 192'(0));
        chk({tag, "_rk_out"}, rk_out, 192'(0));
        chk({tag, "_rk_idx"}, 192'(rk_idx), 192'(0));
        chk({tag, "_rd_data"}, rd_data, 192'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        run(2'd0, K128, 1'b0, 1'b0, 1'b1);

        start   = 1'b1;
        key_len = 2'd3;
        key_in  = K256;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bad_len_err", 192'(err), 192'(1));
        chk("bad_len_busy", 192'(busy), 192'(0));
        chk("bad_len_valid", 192'(rk_valid), 192'(0));
        @(posedge clk);
        #1;
        chk("bad_len_err_pulse", 192'(err), 192'(0));

        run(2'd1, K192, 1'b0, 1'b0, 1'b0);
        run(2'd2, K256, 1'b0, 1'b0, 1'b0);

`ifdef LEA_KEYSCHED_STORE_EN
        for (int k = 31; k >= 0; k--) begin
            rd_idx = 5'(k);
            @(posedge clk);
            #1;
            chk("store_read", rd_data, gold[k]);
        end
`else
        rd_idx = 5'd7;
        @(posedge clk);
        #1;
        chk("no_store_rd_data", rd_data, 192'(0));
`endif

        run(2'd0, K128, 1'b1, 1'b0, 1'b0);
        run(2'd2, K256, 1'b1, 1'b0, 1'b0);
        run(2'd1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            1'b1, 1'b0, 1'b0);
        run(2'd1, K192, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a LEA-128 schedule.
        build_expected(2'd0, K128);
        start    = 1'b1;
        key_len  = 2'd0;
        key_in   = K128;
        rk_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!(rk_valid && rk_idx == 5'd10) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reached_idx10", 192'(rk_idx), 192'(10));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midrst");
        rst = 1'b0;
        rk_ready = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        run(2'd0, K128, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
